// File: rtl/nios_ldac_pkg.sv
// Shared types and constants for the LDAC pulse master.
package nios_ldac_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_WR_LOW,
    ST_HOLD,
    ST_WR_HIGH,
    ST_RD_CHK,
    ST_DONE
  } state_t;

  // LDAC_n is active-low: writing 0 asserts the DAC load strobe.
  localparam logic [31:0] LDAC_ASSERT   = 32'h0;
  localparam logic [31:0] LDAC_DEASSERT = 32'h1;

  // States in which an Avalon write request is presented.
  function automatic logic is_write_state(state_t s);
    return (s == ST_INIT) || (s == ST_WR_LOW) || (s == ST_WR_HIGH);
  endfunction

endpackage

// File: rtl/nios_ldac_pulse_master_if.sv
// Avalon-MM host-to-PIO bus bundle.
interface nios_ldac_pulse_master_if #(
  parameter int ADDR_W = 2
);
  logic [ADDR_W-1:0] avm_address;
  logic              avm_write;
  logic              avm_read;
  logic [31:0]       avm_writedata;
  logic [31:0]       avm_readdata;
  logic              avm_waitrequest;

  modport master (
    output avm_address, avm_write, avm_read, avm_writedata,
    input  avm_readdata, avm_waitrequest
  );

  modport slave (
    input  avm_address, avm_write, avm_read, avm_writedata,
    output avm_readdata, avm_waitrequest
  );
endinterface

// File: rtl/nios_ldac_pulse_master.sv
// Avalon-MM host generating the LDAC_n strobe on a single-bit PIO:
// write 0, hold, write 1, read back and verify bit0.
module nios_ldac_pulse_master
  import nios_ldac_pkg::*;
#(
  parameter int ADDR_W       = 2,
  parameter int PIO_ADDR     = 0,
  parameter int PULSE_CYCLES = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic trigger,
  input  logic clr_err,
  output logic busy,
  output logic done,
  output logic verify_err,
  output logic overrun_err,
  nios_ldac_pulse_master_if.master avm
);

  state_t      state_q, state_d;
  logic [7:0]  counter_q, counter_d;
  logic        pending_q, pending_d;
  logic        verify_err_q, verify_err_d;
  logic        overrun_err_q, overrun_err_d;
  logic        avm_write_q, avm_write_d;
  logic        avm_read_q, avm_read_d;
  logic [31:0] avm_writedata_q, avm_writedata_d;

  logic wr_ack;
  logic rd_ack;
  logic verify_set;
  logic overrun_set;
  logic unused_readdata;

  assign wr_ack = avm_write_q && !avm.avm_waitrequest;
  assign rd_ack = avm_read_q  && !avm.avm_waitrequest;

  // Upper readdata bits carry no meaning for the single-bit PIO.
  assign unused_readdata = ^avm.avm_readdata[31:1];

  // Next state, pending/error bookkeeping and registered bus request.
  // Bus outputs are derived from the next state so a request is presented
  // in the first cycle of its state and stays stable until accepted.
  always_comb begin
    state_d       = state_q;
    counter_d     = counter_q;
    pending_d     = pending_q;
    verify_set    = 1'b0;
    overrun_set   = 1'b0;

    unique case (state_q)
      ST_INIT:    if (wr_ack) state_d = ST_IDLE;
      ST_IDLE: begin
        if (trigger || pending_q) begin
          state_d   = ST_WR_LOW;
          pending_d = 1'b0;
        end
      end
      ST_WR_LOW: begin
        if (wr_ack) begin
          state_d   = ST_HOLD;
          counter_d = 8'(PULSE_CYCLES - 1);
        end
      end
      ST_HOLD: begin
        if (counter_q == '0) state_d = ST_WR_HIGH;
        else                 counter_d = counter_q - 8'd1;
      end
      ST_WR_HIGH: if (wr_ack) state_d = ST_RD_CHK;
      ST_RD_CHK: begin
        if (rd_ack) begin
          verify_set = !avm.avm_readdata[0];
          state_d    = ST_DONE;
        end
      end
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_INIT;
    endcase

    if (trigger && (state_q != ST_IDLE)) begin
      if (pending_q) overrun_set = 1'b1;
      else           pending_d   = 1'b1;
    end

    // Set takes priority over a same-cycle clear.
    verify_err_d  = (clr_err ? 1'b0 : verify_err_q)  | verify_set;
    overrun_err_d = (clr_err ? 1'b0 : overrun_err_q) | overrun_set;

    avm_write_d     = is_write_state(state_d);
    avm_read_d      = (state_d == ST_RD_CHK);
    avm_writedata_d = (state_d == ST_WR_LOW) ? LDAC_ASSERT : LDAC_DEASSERT;
  end

  // State and output registers; reset abandons any in-flight request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_INIT;
      counter_q       <= '0;
      pending_q       <= 1'b0;
      verify_err_q    <= 1'b0;
      overrun_err_q   <= 1'b0;
      avm_write_q     <= 1'b0;
      avm_read_q      <= 1'b0;
      avm_writedata_q <= '0;
    end else begin
      state_q         <= state_d;
      counter_q       <= counter_d;
      pending_q       <= pending_d;
      verify_err_q    <= verify_err_d;
      overrun_err_q   <= overrun_err_d;
      avm_write_q     <= avm_write_d;
      avm_read_q      <= avm_read_d;
      avm_writedata_q <= avm_writedata_d;
    end
  end

  assign avm.avm_address   = ADDR_W'(PIO_ADDR);
  assign avm.avm_write     = avm_write_q;
  assign avm.avm_read      = avm_read_q;
  assign avm.avm_writedata = avm_writedata_q;

  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign verify_err  = verify_err_q;
  assign overrun_err = overrun_err_q;

endmodule

// File: tb/tb_nios_ldac_pulse_master.sv
// Scoreboard bench for nios_ldac_pulse_master with a behavioural PIO slave.
module tb_nios_ldac_pulse_master;

  localparam int P        = 8;
  localparam int ADDR_W   = 2;
  localparam int PIO_ADDR = 0;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic trigger = 1'b0;
  logic clr_err = 1'b0;
  logic busy, done, verify_err, overrun_err;

  nios_ldac_pulse_master_if #(.ADDR_W(ADDR_W)) bus ();

  nios_ldac_pulse_master #(
    .ADDR_W(ADDR_W), .PIO_ADDR(PIO_ADDR), .PULSE_CYCLES(P)
  ) dut (
    .clk(clk), .reset_n(reset_n), .trigger(trigger), .clr_err(clr_err),
    .busy(busy), .done(done), .verify_err(verify_err),
    .overrun_err(overrun_err), .avm(bus)
  );

  always #5 clk = ~clk;

  // Behavioural single-bit PIO slave (out_port resets to 0).
  logic        out_port;
  logic        force_bad = 1'b0;
  logic [30:0] rd_hi = '0;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) out_port <= 1'b0;
    else if (bus.avm_write && !bus.avm_waitrequest &&
             bus.avm_address == ADDR_W'(PIO_ADDR))
      out_port <= bus.avm_writedata[0];
  end
  assign bus.avm_readdata = {rd_hi, out_port & ~force_bad};

  int tests = 0;
  int fails = 0;
  int stall_n = 0;

  typedef struct {int kind; int data; int width;} xfer_t;  // kind 0=write 1=read
  xfer_t xq[$];
  bit    dq[$];
  bit    verr_m = 1'b0;
  bit    ovr_m  = 1'b0;

  task automatic check(string name, longint act, longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected bus traffic and done-time status of one pulse sequence.
  task automatic push_seq(bit bad, int stall);
    xq.push_back('{0, 0, 0});
    xq.push_back('{0, 1, P + 1 + stall});
    xq.push_back('{1, 0, 0});
    verr_m = verr_m | bad;
    dq.push_back(verr_m);
  endtask

  task automatic pulse_trigger();
    @(negedge clk); trigger = 1'b1;
    @(negedge clk); trigger = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk); clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
    verr_m = 1'b0;
    ovr_m  = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    int idle = 0;
    while (idle < 3 && n < 400) begin
      @(negedge clk); #3;
      n++;
      if (!busy) idle++; else idle = 0;
    end
    if (idle < 3) begin
      tests++; fails++;
      $display("FAIL wait_idle: busy still %0d after %0d cycles, required 0", busy, n);
    end
  endtask

  task automatic wait_out_low();
    int n = 0;
    while (out_port !== 1'b0 && n < 200) begin
      @(negedge clk); #3;
      n++;
    end
    if (out_port !== 1'b0) begin
      tests++; fails++;
      $display("FAIL wait_out_low: out_port %0d, required 0", out_port);
    end
  endtask

  // Waitrequest generator: each transfer stalls for stall_n cycles.
  int wr_cnt = 0;
  bit last_done = 1'b0;
  initial begin
    bus.avm_waitrequest = 1'b0;
    forever begin
      @(negedge clk);
      rd_hi = 31'($urandom);
      if (last_done) wr_cnt = 0;
      if (!(bus.avm_write || bus.avm_read)) begin
        bus.avm_waitrequest = 1'b0;
        wr_cnt = 0;
      end else if (wr_cnt < stall_n) begin
        bus.avm_waitrequest = 1'b1;
        wr_cnt++;
      end else begin
        bus.avm_waitrequest = 1'b0;
      end
      last_done = (bus.avm_write || bus.avm_read) && !bus.avm_waitrequest;
    end
  end

  // Monitor: pops expectations whenever the DUT completes a transfer or pulses done.
  int cyc = 0;
  int t0 = 0;
  bit in_pulse = 1'b0;
  bit prev_stall = 1'b0;
  logic [35:0] prev_bus = '0;
  initial begin
    xfer_t x;
    forever begin
      @(negedge clk); #2;
      cyc++;
      if (!reset_n) begin
        in_pulse = 1'b0;
        prev_stall = 1'b0;
      end else begin
        if (prev_stall)
          check("avm_stable",
                longint'({bus.avm_address, bus.avm_write, bus.avm_read, bus.avm_writedata}),
                longint'(prev_bus));
        if (bus.avm_write || bus.avm_read) begin
          check("wr_rd_exclusive", longint'(bus.avm_write && bus.avm_read), 0);
          check("avm_address", longint'(bus.avm_address), PIO_ADDR);
        end
        if ((bus.avm_write || bus.avm_read) && !bus.avm_waitrequest) begin
          if (xq.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_xfer: write=%0d read=%0d, required none",
                     bus.avm_write, bus.avm_read);
          end else begin
            x = xq.pop_front();
            check("xfer_kind", longint'(bus.avm_read), x.kind);
            if (bus.avm_write) begin
              check("writedata", longint'(bus.avm_writedata), x.data);
              if (bus.avm_writedata == 32'h0) begin
                in_pulse = 1'b1;
                t0 = cyc;
              end else if (in_pulse) begin
                check("pulse_width", cyc - t0, x.width);
                in_pulse = 1'b0;
              end
            end
          end
        end
        if (done) begin
          if (dq.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_done: done=1, required 0");
          end else begin
            check("verify_err_at_done", longint'(verify_err), longint'(dq.pop_front()));
          end
        end
        prev_stall = (bus.avm_write || bus.avm_read) && bus.avm_waitrequest;
        prev_bus   = {bus.avm_address, bus.avm_write, bus.avm_read, bus.avm_writedata};
      end
    end
  end

  // Stimulus
  initial begin
    int stall;
    bit bad;
    int n;

    // Reset values, then INIT park write in the first cycle after release.
    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs",
          longint'({bus.avm_write, bus.avm_read, bus.avm_writedata, done, busy, verify_err, overrun_err}),
          longint'({1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0}));
    xq.push_back('{0, 1, -1});
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    check("init_write_cycle1", longint'({bus.avm_write, bus.avm_writedata[0], busy}), 3'b111);
    @(posedge clk); #1;
    check("init_idle_cycle2", longint'({bus.avm_write, busy}), 2'b00);
    check("init_out_port", longint'(out_port), 1);

    // Single pulse, no stalls.
    stall_n = 0;
    push_seq(1'b0, 0);
    pulse_trigger();
    wait_idle();
    check("verify_err_good", longint'(verify_err), 0);

    // Every transfer stalled 3 cycles.
    stall_n = 3;
    push_seq(1'b0, 3);
    pulse_trigger();
    wait_idle();
    stall_n = 0;

    // Trigger in HOLD queues one sequence; a second in WR_HIGH overruns.
    push_seq(1'b0, 0);
    push_seq(1'b0, 0);
    pulse_trigger();
    wait_out_low();
    pulse_trigger();
    n = 0;
    do begin
      @(negedge clk); #3;
      n++;
    end while (!(bus.avm_write && bus.avm_writedata == 32'h1) && n < 100);
    trigger = 1'b1;
    ovr_m = 1'b1;
    @(negedge clk); trigger = 1'b0;
    wait_idle();
    check("overrun_set", longint'(overrun_err), longint'(ovr_m));
    check("overrun_queue_drained", dq.size(), 0);
    pulse_clr();
    #1;
    check("overrun_cleared", longint'(overrun_err), 0);

    // Bad readback: sticky across a following good sequence until cleared.
    force_bad = 1'b1;
    push_seq(1'b1, 0);
    pulse_trigger();
    wait_idle();
    force_bad = 1'b0;
    check("verify_err_set", longint'(verify_err), 1);
    push_seq(1'b0, 0);
    pulse_trigger();
    wait_idle();
    check("verify_err_sticky", longint'(verify_err), 1);
    pulse_clr();
    #1;
    check("verify_err_cleared", longint'(verify_err), 0);

    // clr_err held through a failing readback: the set wins.
    force_bad = 1'b1;
    push_seq(1'b1, 0);
    clr_err = 1'b1;
    pulse_trigger();
    wait_idle();
    clr_err = 1'b0;
    force_bad = 1'b0;
    verr_m = 1'b0;
    check("clr_during_idle", longint'(verify_err), 0);

    // Randomized sequences.
    for (int i = 0; i < 12; i++) begin
      stall = int'($urandom_range(0, 3));
      bad   = ($urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      stall_n   = stall;
      force_bad = bad;
      push_seq(bad, stall);
      pulse_trigger();
      wait_idle();
      force_bad = 1'b0;
      if ($urandom_range(0, 2) == 0) begin
        pulse_clr();
        #1;
      end
      check("rand_verify_err", longint'(verify_err), longint'(verr_m));
    end
    stall_n = 0;

    // Reset during HOLD with a pending trigger.
    push_seq(1'b0, 0);
    pulse_trigger();
    wait_out_low();
    pulse_trigger();
    @(negedge clk); #1;
    reset_n = 1'b0;
    #1;
    check("midreset_outputs",
          longint'({bus.avm_write, bus.avm_read, bus.avm_writedata, done, busy, verify_err, overrun_err}),
          longint'({1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0}));
    xq.delete();
    dq.delete();
    verr_m = 1'b0;
    ovr_m  = 1'b0;
    xq.push_back('{0, 1, -1});
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    #3;
    check("midreset_out_port", longint'(out_port), 1);
    check("midreset_idle", longint'(busy), 0);

    check("xfer_queue_drained", xq.size(), 0);
    check("done_queue_drained", dq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #500000;
    $display("FAIL timeout: simulation still running, required $finish");
    $fatal(1, "timeout");
  end

endmodule
